// File: rtl/io_port_if.sv
// Handshake bundle for io_port: input-byte FIFO producer side and
// output holding-register consumer side.
interface io_port_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_count;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       ovf;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, in_count, out_data, out_valid, ovf
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, in_count, out_data, out_valid, ovf
  );
endinterface

// File: rtl/io_port.sv
// Sequencer I/O port: 4-deep input FIFO delivered onto the shared bus one
// byte per read instruction, plus a single output holding register.
module io_port (
  input  logic       clk,
  input  logic       clear,
  inout  wire  [7:0] bus,
  input  logic       hlt,
  input  logic       tx,
  output logic       rx,
  io_port_if.slave   io
);

  typedef enum logic [1:0] {IDLE, DRIVE, RELEASE} state_t;

  state_t     state_reg, state_next;
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr_reg, rd_ptr_reg;
  logic [2:0] count_reg;
  logic [7:0] drive_reg;
  logic       rx_reg;
  logic       drive_en;
  logic [7:0] out_data_reg;
  logic       out_valid_reg;
  logic       ovf_reg;
  logic       push, pop;

  assign io.in_ready  = (count_reg < 3'd4);
  assign io.in_count  = count_reg;
  assign io.out_data  = out_data_reg;
  assign io.out_valid = out_valid_reg;
  assign io.ovf       = ovf_reg;
  assign rx           = rx_reg;

  assign push = io.in_valid & io.in_ready;
  assign pop  = (state_reg == IDLE) & hlt & (count_reg != 3'd0);

  assign bus = drive_en ? drive_reg : 8'hzz;

  // State register; rx is registered from the next state so it is high
  // for exactly the one DRIVE cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg <= IDLE;
      rx_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      rx_reg    <= (state_next == DRIVE);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (hlt && count_reg != 3'd0) state_next = DRIVE;
      DRIVE:   state_next = RELEASE;
      RELEASE: if (!hlt) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    drive_en = (state_reg == DRIVE);
  end

  // Storage has no reset; clear only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (push && !clear) fifo_mem[wr_ptr_reg] <= io.in_data;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
      drive_reg  <= 8'h00;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 2'd1;
        drive_reg  <= fifo_mem[rd_ptr_reg];
      end
      count_reg <= count_reg + {2'b00, push} - {2'b00, pop};
    end
  end

  // A tx while the previous byte is still unconsumed drops the new byte.
  always_ff @(posedge clk) begin
    if (clear) begin
      out_data_reg  <= 8'h00;
      out_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
    end else if (tx) begin
      if (!out_valid_reg || io.out_ready) begin
        out_data_reg  <= bus;
        out_valid_reg <= 1'b1;
      end else begin
        ovf_reg <= 1'b1;
      end
    end else if (out_valid_reg && io.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_port.sv
// Randomized and directed bench for io_port against a queue-based model of
// the input FIFO, the per-read-instruction delivery and the output register.
module tb_io_port;
  logic       clk = 1'b0;
  logic       clear, hlt, tx;
  logic       rx;
  wire  [7:0] bus;
  logic       tb_drive;
  logic [7:0] tb_bus;

  io_port_if io ();

  assign bus = tb_drive ? tb_bus : 8'hzz;

  io_port dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus),
    .hlt   (hlt),
    .tx    (tx),
    .rx    (rx),
    .io    (io)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [7:0] q[$];
  bit         m_lock, m_rx, m_ov, m_ovf;
  logic [7:0] m_drv, m_od;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    logic [7:0] bus_v;
    int         sz;
    bit         do_push, do_pop;
    bus_v = m_rx ? m_drv : tb_bus;
    sz    = q.size();
    if (clear) begin
      q.delete();
      m_lock = 0; m_rx = 0; m_drv = 8'h00;
      m_od = 8'h00; m_ov = 0; m_ovf = 0;
      return;
    end
    do_push = io.in_valid && (sz < 4);
    do_pop  = 0;
    if (m_rx)        m_rx = 0;
    else if (m_lock) begin if (!hlt) m_lock = 0; end
    else if (hlt && sz > 0) do_pop = 1;
    if (do_pop) begin
      m_drv  = q.pop_front();
      m_rx   = 1;
      m_lock = 1;
      $display("[TB] read delivers %02h", m_drv);
    end
    if (do_push) q.push_back(io.in_data);
    if (tx) begin
      if (!m_ov || io.out_ready) begin
        m_od = bus_v;
        m_ov = 1;
        $display("[TB] tx captures %02h", bus_v);
      end else begin
        m_ovf = 1;
        $display("[TB] tx drops %02h", bus_v);
      end
    end else if (m_ov && io.out_ready) begin
      m_ov = 0;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    tb_drive = !m_rx;
    #1;
    check("rx", rx, m_rx);
    check("in_count", io.in_count, q.size());
    check("in_ready", io.in_ready, q.size() < 4);
    check("out_data", io.out_data, m_od);
    check("out_valid", io.out_valid, m_ov);
    check("ovf", io.ovf, m_ovf);
    check("bus", bus, m_rx ? m_drv : tb_bus);
  endtask

  task automatic quiet();
    clear = 0; hlt = 0; tx = 0;
    io.in_valid = 0; io.in_data = 8'h00; io.out_ready = 0;
  endtask

  task automatic do_clear();
    quiet();
    clear = 1;
    step();
    clear = 0;
  endtask

  initial begin
    logic [7:0] next_exp;
    int         pushed;
    quiet();
    tb_drive = 1;
    tb_bus   = 8'hA5;
    m_lock = 0; m_rx = 0; m_ov = 0; m_ovf = 0; m_drv = 0; m_od = 0;

    // Reset state
    do_clear();
    check("rst_count", io.in_count, 0);
    check("rst_ready", io.in_ready, 1);
    check("rst_out_data", io.out_data, 8'h00);

    // Fill to four; fifth byte refused
    for (int i = 0; i < 4; i++) begin
      io.in_valid = 1; io.in_data = 8'h11 * (i + 1);
      step();
    end
    io.in_data = 8'h55;
    step();
    check("full_count", io.in_count, 4);
    check("full_ready", io.in_ready, 0);
    io.in_valid = 0;

    // Single byte delivered once per hlt episode
    do_clear();
    io.in_valid = 1; io.in_data = 8'h5A;
    step();
    io.in_valid = 0; hlt = 1;
    step();
    check("deliver_rx", rx, 1);
    check("deliver_bus", bus, 8'h5A);
    check("deliver_count", io.in_count, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_second_rx", rx, 0);
    end

    // hlt waits on empty FIFO, then push releases it
    do_clear();
    hlt = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("empty_wait_rx", rx, 0);
    end
    io.in_valid = 1; io.in_data = 8'hC3;
    step();
    check("push_edge_rx", rx, 0);
    io.in_valid = 0;
    step();
    check("late_rx", rx, 1);
    check("late_bus", bus, 8'hC3);
    hlt = 0;
    step();

    // Output overflow
    do_clear();
    tx = 1; tb_bus = 8'h7E;
    step();
    tb_bus = 8'h81;
    step();
    check("ovf_keep_data", io.out_data, 8'h7E);
    check("ovf_set", io.ovf, 1);
    tx = 0; io.out_ready = 1;
    step();
    check("ovf_drain_valid", io.out_valid, 0);
    check("ovf_sticky", io.ovf, 1);
    io.out_ready = 0;

    // Pointer wrap with interleaved push/pop
    do_clear();
    pushed = 0;
    next_exp = 8'h00;
    for (int c = 0; c < 48; c++) begin
      io.in_valid = (pushed < 10) && (c % 2 == 0);
      io.in_data  = pushed[7:0];
      hlt = (c % 4 == 1) || (c % 4 == 2);
      if (io.in_valid && io.in_ready) pushed++;
      step();
      if (rx) begin
        check("wrap_order", bus, next_exp);
        next_exp++;
      end
    end
    check("wrap_all_popped", next_exp, 8'd10);
    quiet();

    // clear during DRIVE with three bytes left
    do_clear();
    tx = 1; tb_bus = 8'h3C;
    step();
    tb_bus = 8'h3D;
    step();
    tx = 0;
    for (int i = 0; i < 4; i++) begin
      io.in_valid = 1; io.in_data = 8'hE0 + 8'(i);
      step();
    end
    io.in_valid = 0; hlt = 1;
    step();
    check("pre_clear_rx", rx, 1);
    check("pre_clear_count", io.in_count, 3);
    clear = 1;
    step();
    check("mid_clear_rx", rx, 0);
    check("mid_clear_count", io.in_count, 0);
    check("mid_clear_valid", io.out_valid, 0);
    check("mid_clear_ovf", io.ovf, 0);
    clear = 0;
    step();
    check("after_clear_rx", rx, 0);
    quiet();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      clear        = ($urandom_range(0, 99) == 0);
      hlt          = ($urandom_range(0, 2) != 0);
      tx           = ($urandom_range(0, 3) == 0);
      io.in_valid  = ($urandom_range(0, 2) == 0);
      io.in_data   = 8'($urandom);
      io.out_ready = ($urandom_range(0, 2) == 0);
      tb_bus       = 8'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
